// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage and its instruction buffer.
package if_stage_pkg;
  localparam int          FS_TO_DS_BUS_W = 64;
  localparam logic [31:0] NOP_INST       = 32'h03400000;
  localparam logic [31:0] RESET_PC_DEF   = 32'h1bc00000;
endpackage

// File: rtl/if_inst_buf.sv
// One-entry capture/bypass buffer that holds the returned SRAM word while decode stalls.
module if_inst_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_fs_valid,
  input  logic        i_xfer,
  input  logic        i_flush,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_inst,
  output logic        o_buf_valid
);

  logic [31:0] r_inst_buf;
  logic        r_inst_buf_valid;

  // The SRAM output is only trustworthy in the first cycle after the request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_inst_buf_valid <= 1'b0;
    end else if (i_xfer || i_flush) begin
      r_inst_buf_valid <= 1'b0;
    end else if (i_fs_valid) begin
      r_inst_buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_fs_valid && !r_inst_buf_valid && !i_xfer) begin
      r_inst_buf <= i_rdata;
    end
  end

  assign o_inst      = r_inst_buf_valid ? r_inst_buf : i_rdata;
  assign o_buf_valid = r_inst_buf_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the inst SRAM and hands {pc, inst} to decode.
// Optional build macro IF_ADEF_EN enables fetch-address-error reporting for misaligned PCs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  output logic                      inst_sram_en,
  output logic                      inst_sram_wen,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic [31:0]               inst_sram_rdata,
  input  logic                      ds_allowin,
  input  logic                      br_taken,
  input  logic [31:0]               br_target,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
  output logic                      fs_excp_adef
);

  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_br_pend;
  logic [31:0] r_br_pend_target;
  logic        r_fs_cancel;

  logic        w_fs_ready_go;
  logic        w_fs_allowin;
  logic        w_xfer;
  logic        w_req;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;
  logic [31:0] w_buf_inst;
  logic [31:0] w_fs_inst;
  logic        w_buf_valid;

  assign w_fs_ready_go  = r_fs_valid & ~r_fs_cancel;
  assign w_fs_allowin   = ~r_fs_valid | (w_fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = resetn & r_fs_valid & w_fs_ready_go;
  assign w_xfer         = fs_to_ds_valid & ds_allowin;
  assign w_req          = resetn & w_fs_allowin;

  assign w_seq_pc = r_fs_pc + 32'd4;
  assign w_nextpc = br_taken  ? br_target        :
                    r_br_pend ? r_br_pend_target :
                                w_seq_pc;

  // A redirect that cannot be issued now is parked until fs_allowin rises.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fs_valid  <= 1'b0;
      r_fs_pc     <= RESET_PC - 32'd4;
      r_br_pend   <= 1'b0;
      r_fs_cancel <= 1'b0;
    end else begin
      r_fs_cancel <= 1'b0;
      if (w_fs_allowin) begin
        r_fs_valid <= 1'b1;
        r_fs_pc    <= w_nextpc;
        r_br_pend  <= 1'b0;
      end else if (br_taken) begin
        r_fs_valid <= 1'b0;
        r_br_pend  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (br_taken && !w_fs_allowin) begin
      r_br_pend_target <= br_target;
    end
  end

  if_inst_buf u_inst_buf (
    .clk         (clk),
    .resetn      (resetn),
    .i_fs_valid  (r_fs_valid),
    .i_xfer      (w_xfer),
    .i_flush     (br_taken),
    .i_rdata     (inst_sram_rdata),
    .o_inst      (w_buf_inst),
    .o_buf_valid (w_buf_valid)
  );

`ifdef IF_ADEF_EN
  logic r_fs_adef;
  logic w_misalign;

  assign w_misalign = |w_nextpc[1:0];

  // A misaligned fetch is accepted as a slot but never reaches the SRAM.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fs_adef <= 1'b0;
    end else if (w_fs_allowin) begin
      r_fs_adef <= w_misalign;
    end
  end

  assign inst_sram_en   = w_req & ~w_misalign;
  assign inst_sram_addr = w_nextpc;
  assign w_fs_inst      = r_fs_adef ? NOP_INST : w_buf_inst;
  assign fs_excp_adef   = fs_to_ds_valid & r_fs_adef;
`else
  assign inst_sram_en   = w_req;
  assign inst_sram_addr = {w_nextpc[31:2], 2'b00};
  assign w_fs_inst      = w_buf_inst;
  assign fs_excp_adef   = 1'b0;
`endif

  assign inst_sram_wen   = 1'b0;
  assign inst_sram_wdata = 32'd0;
  assign fs_to_ds_bus    = {r_fs_pc, w_fs_inst};

  logic w_unused;
  assign w_unused = w_buf_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, stall buffering, redirects, reset and misaligned fetch.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk;
  logic        resetn;
  logic        inst_sram_en;
  logic        inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        fs_excp_adef;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .fs_excp_adef    (fs_excp_adef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5a5a5a5a;
  endfunction

  // Synchronous SRAM: one-cycle latency, garbage whenever no read is requested.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_vld"}, {63'd0, fs_to_ds_valid}, 64'd1);
    chk({tag, "_bus"}, fs_to_ds_bus, {pc, inst});
  endtask

  initial begin
    resetn     = 1'b0;
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'd0;

    next(); next();
    smp();
    chk("rst_en",   {63'd0, inst_sram_en},   64'd0);
    chk("rst_vld",  {63'd0, fs_to_ds_valid}, 64'd0);
    chk("rst_adef", {63'd0, fs_excp_adef},   64'd0);
    chk("wen_wdata", {31'd0, inst_sram_wen, inst_sram_wdata}, 64'd0);

    // Sequential fetch after reset release
    next(); resetn = 1'b1;
    smp();
    chk("a_en",   {63'd0, inst_sram_en}, 64'd1);
    chk("a_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00000});
    chk("a_vld",  {63'd0, fs_to_ds_valid}, 64'd0);
    next(); smp();
    chk("b_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00004});
    chk_bus("b", 32'h1bc00000, mem(32'h1bc00000));
    next(); smp();
    chk("c_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00008});
    chk_bus("c", 32'h1bc00004, mem(32'h1bc00004));

    // Decode stalls three cycles at 1bc00008
    for (int i = 0; i < 3; i++) begin
      next(); ds_allowin = 1'b0;
      smp();
      chk("stall_en", {63'd0, inst_sram_en}, 64'd0);
      chk_bus("stall", 32'h1bc00008, mem(32'h1bc00008));
    end
    next(); ds_allowin = 1'b1;
    smp();
    chk("g_en",   {63'd0, inst_sram_en}, 64'd1);
    chk("g_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc0000c});
    chk_bus("g", 32'h1bc00008, mem(32'h1bc00008));

    // Redirect while fs_allowin=1
    next(); br_taken = 1'b1; br_target = 32'h1bc00100;
    smp();
    chk("h_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00100});
    chk_bus("h", 32'h1bc0000c, mem(32'h1bc0000c));
    next(); br_taken = 1'b0;
    smp();
    chk_bus("i", 32'h1bc00100, mem(32'h1bc00100));
    chk("i_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00104});

    // Redirect during a stall
    next(); ds_allowin = 1'b0;
    smp();
    chk("j_en", {63'd0, inst_sram_en}, 64'd0);
    chk_bus("j", 32'h1bc00104, mem(32'h1bc00104));
    next(); br_taken = 1'b1; br_target = 32'h1bc00200;
    smp();
    chk("k_en", {63'd0, inst_sram_en}, 64'd0);
    next(); br_taken = 1'b0;
    smp();
    chk("l_vld",  {63'd0, fs_to_ds_valid}, 64'd0);
    chk("l_en",   {63'd0, inst_sram_en}, 64'd1);
    chk("l_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00200});
    next(); smp();
    chk("m_en", {63'd0, inst_sram_en}, 64'd0);
    chk_bus("m", 32'h1bc00200, mem(32'h1bc00200));

    // Reset while a redirect is pending
    next(); br_taken = 1'b1; br_target = 32'h1bc00300;
    smp();
    chk("n_en", {63'd0, inst_sram_en}, 64'd0);
    next(); br_taken = 1'b0; resetn = 1'b0;
    smp();
    chk("o_en",  {63'd0, inst_sram_en},   64'd0);
    chk("o_vld", {63'd0, fs_to_ds_valid}, 64'd0);
    next(); resetn = 1'b1; ds_allowin = 1'b1;
    smp();
    chk("p_vld",  {63'd0, fs_to_ds_valid}, 64'd0);
    chk("p_en",   {63'd0, inst_sram_en}, 64'd1);
    chk("p_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00000});
    next(); smp();
    chk_bus("q", 32'h1bc00000, mem(32'h1bc00000));
    chk("q_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00004});

    // Misaligned redirect target
    next(); br_taken = 1'b1; br_target = 32'h1bc00102;
    smp();
`ifdef IF_ADEF_EN
    chk("r_en",   {63'd0, inst_sram_en}, 64'd0);
    chk("r_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00102});
    next(); br_taken = 1'b0;
    smp();
    chk_bus("s", 32'h1bc00102, NOP_INST);
    chk("s_adef", {63'd0, fs_excp_adef}, 64'd1);
    chk("s_en",   {63'd0, inst_sram_en}, 64'd0);
    next(); br_taken = 1'b1; br_target = 32'h1bc00400;
    smp();
    chk("t_en",   {63'd0, inst_sram_en}, 64'd1);
    chk("t_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00400});
    chk("t_adef", {63'd0, fs_excp_adef}, 64'd1);
    next(); br_taken = 1'b0;
    smp();
    chk_bus("u", 32'h1bc00400, mem(32'h1bc00400));
    chk("u_adef", {63'd0, fs_excp_adef}, 64'd0);
`else
    chk("r_en",   {63'd0, inst_sram_en}, 64'd1);
    chk("r_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00100});
    next(); br_taken = 1'b0;
    smp();
    chk_bus("s", 32'h1bc00102, mem(32'h1bc00100));
    chk("s_adef", {63'd0, fs_excp_adef}, 64'd0);
    chk("s_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1bc00104});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
